// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle sequencer and the 4-bit CPU datapath.
// With MULTICYCLE_MEM_WAIT_EN defined the bundle also carries mem_ready.
interface multicycle_controller_if;
`ifdef MULTICYCLE_MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic [2:0] op;
  logic [3:0] funct;
  logic       zero;
  logic       pcen;
  logic       iord;
  logic       irwrite;
  logic       memwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  modport master (
`ifdef MULTICYCLE_MEM_WAIT_EN
    input  mem_ready,
`endif
    input  op, funct, zero,
    output pcen, iord, irwrite, memwrite, memtoreg, regdst, regwrite,
    output alusrca, alusrcb, pcsrc, alucontrol, illegal, state
  );

  modport slave (
`ifdef MULTICYCLE_MEM_WAIT_EN
    output mem_ready,
`endif
    output op, funct, zero,
    input  pcen, iord, irwrite, memwrite, memtoreg, regdst, regwrite,
    input  alusrca, alusrcb, pcsrc, alucontrol, illegal, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Fetch/decode/execute/memory/writeback sequencer for the multicycle 4-bit CPU.
// Optional memory wait states are enabled with `define MULTICYCLE_MEM_WAIT_EN.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input logic               clk,
  input logic               reset,
  multicycle_controller_if.master bus
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_LW    = 3'b001;
  localparam logic [2:0] OP_SW    = 3'b010;
  localparam logic [2:0] OP_BEQ   = 3'b011;
  localparam logic [2:0] OP_ADDI  = 3'b100;
  localparam logic [2:0] OP_J     = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic       w_ready;
  logic       w_pcwrite;
  logic       w_branch;
  logic [1:0] w_aluop;
  logic [2:0] w_funct_alu;
  logic       w_funct_bad;
  logic       w_op_bad;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign w_ready = bus.mem_ready;
`else
  assign w_ready = 1'b1;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= RESET_STATE;
    else       r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:   w_next_state = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_RTYPE:      w_next_state = S_EXECUTE;
          OP_LW, OP_SW:  w_next_state = S_MEMADR;
          OP_BEQ:        w_next_state = S_BRANCH;
          OP_ADDI:       w_next_state = S_ADDIEX;
          OP_J:          w_next_state = S_JUMP;
          default:       w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next_state = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next_state = w_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_next_state = w_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: w_next_state = S_ALUWB;
      S_ADDIEX:  w_next_state = S_ADDIWB;
      default:   w_next_state = S_FETCH;
    endcase
  end

  assign w_op_bad = (bus.op == 3'b110) || (bus.op == 3'b111);

  always_comb begin
    w_funct_alu = 3'b010;
    w_funct_bad = 1'b0;
    case (bus.funct)
      4'b0000: w_funct_alu = 3'b010;
      4'b0001: w_funct_alu = 3'b110;
      4'b0010: w_funct_alu = 3'b000;
      4'b0011: w_funct_alu = 3'b001;
      4'b0100: w_funct_alu = 3'b111;
      default: w_funct_bad = 1'b1;
    endcase
  end

  // Moore decode of the state; the enables are masked while reset is held.
  always_comb begin
    w_pcwrite      = 1'b0;
    w_branch       = 1'b0;
    w_aluop        = ALUOP_ADD;
    bus.iord       = 1'b0;
    bus.irwrite    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regdst     = 1'b0;
    bus.regwrite   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.pcsrc      = 2'b00;
    bus.illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.irwrite = w_ready;
        bus.alusrcb = 2'b01;
        w_pcwrite   = w_ready;
      end
      S_DECODE: begin
        bus.alusrcb = 2'b10;
        bus.illegal = w_op_bad;
      end
      S_MEMADR, S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      S_MEMRD:  bus.iord = 1'b1;
      S_MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        bus.iord     = 1'b1;
        bus.memwrite = w_ready;
      end
      S_EXECUTE: begin
        bus.alusrca = 1'b1;
        w_aluop     = ALUOP_FUNCT;
        bus.illegal = w_funct_bad;
      end
      S_ALUWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
      end
      S_BRANCH: begin
        bus.alusrca = 1'b1;
        w_aluop     = ALUOP_SUB;
        w_branch    = 1'b1;
        bus.pcsrc   = 2'b01;
      end
      S_ADDIWB: bus.regwrite = 1'b1;
      S_JUMP: begin
        bus.pcsrc = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase

    if (reset) begin
      w_pcwrite    = 1'b0;
      w_branch     = 1'b0;
      bus.irwrite  = 1'b0;
      bus.memwrite = 1'b0;
      bus.regwrite = 1'b0;
      bus.illegal  = 1'b0;
    end
  end

  always_comb begin
    bus.alucontrol = 3'b010;
    case (w_aluop)
      ALUOP_SUB:   bus.alucontrol = 3'b110;
      ALUOP_FUNCT: bus.alucontrol = w_funct_alu;
      default:     bus.alucontrol = 3'b010;
    endcase
  end

  assign bus.pcen  = w_pcwrite | (w_branch & bus.zero);
  assign bus.state = r_state;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM for the multicycle build of the 4-bit CPU. It replaces the single-cycle decoder when instruction memory and data memory share one port and the ALU also computes PC+1 and branch targets.
- Decodes op/funct from the instruction register, steps the datapath through fetch/decode/execute/memory/writeback, and drives every datapath enable and mux select.
- Sits beside the datapath; its outputs feed the datapath directly.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH); exists for bring-up only, production keeps the default.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  3  opcode field from the instruction register.
- funct  input  4  function field from the instruction register (R-type only).
- zero  input  1  ALU zero flag, combinational from the datapath in the current cycle.
- pcen  output  1  PC register enable; equals pcwrite | (branch & zero).
- iord  output  1  0 = memory address from PC, 1 = from ALUOut.
- irwrite  output  1  instruction register load enable.
- memwrite  output  1  data memory write enable.
- memtoreg  output  1  register writeback source: 1 = memory data register, 0 = ALUOut.
- regdst  output  1  destination register select: 1 = rd, 0 = rt.
- regwrite  output  1  register file write enable.
- alusrca  output  1  ALU A source: 0 = PC, 1 = register A.
- alusrcb  output  2  ALU B source: 00 = register B, 01 = constant 1, 10 = sign-extended immediate.
- pcsrc  output  2  next-PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alucontrol  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- illegal  output  1  one-cycle pulse in DECODE on an unknown opcode, or in EXECUTE on an unknown funct.
- state  output  4  current state, for debug and bench use.

Behaviour:
- Opcodes: 000 R-type, 001 LW, 010 SW, 011 BEQ, 100 ADDI, 101 J. Opcodes 110 and 111 are illegal.
- funct decode (R-type, aluop = 10):
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt.
  - Any other funct: alucontrol = 010 and illegal pulses.
- Internal aluop: 00 = add, 01 = sub, 10 = decode funct.
- States and encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - EXECUTE = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11
  - Codes 12..15 are unreachable and return to FETCH on the next clock.
- Outputs per state (every output not listed is 0; alusrcb/pcsrc default 00; alucontrol default 010):
  - FETCH: iord = 0, irwrite = 1, alusrca = 0, alusrcb = 01, add, pcsrc = 00, pcwrite = 1. Next state DECODE.
  - DECODE: alusrca = 0, alusrcb = 10, add (branch target into ALUOut). Next state by op:
    - 000 → EXECUTE
    - 001 or 010 → MEMADR
    - 011 → BRANCH
    - 100 → ADDIEX
    - 101 → JUMP
    - illegal → FETCH, with illegal = 1.
  - MEMADR: alusrca = 1, alusrcb = 10, add. Next: op = LW → MEMRD, else MEMWR.
  - MEMRD: iord = 1. Next MEMWB.
  - MEMWB: regwrite = 1, memtoreg = 1, regdst = 0. Next FETCH.
  - MEMWR: iord = 1, memwrite = 1. Next FETCH.
  - EXECUTE: alusrca = 1, alusrcb = 00, aluop = 10. Next ALUWB.
  - ALUWB: regwrite = 1, regdst = 1, memtoreg = 0. Next FETCH.
  - BRANCH: alusrca = 1, alusrcb = 00, sub, branch = 1, pcsrc = 01. Next FETCH.
  - ADDIEX: alusrca = 1, alusrcb = 10, add. Next ADDIWB.
  - ADDIWB: regwrite = 1, regdst = 0, memtoreg = 0. Next FETCH.
  - JUMP: pcsrc = 10, pcwrite = 1. Next FETCH.
- Outputs are Moore: decoded from the state register only, except:
  - pcen depends on zero in the same cycle.
  - alucontrol and illegal depend on funct/op in the same cycle.
- Latency in cycles, counted from FETCH through the last state:
  - R-type 4, LW 5, SW 4, BEQ 3, ADDI 4, J 3.
- Reset:
  - Reset asserted at any clock edge, including mid-instruction, forces state = FETCH on that edge.
  - While reset = 1, every enable (pcen, irwrite, memwrite, regwrite) is held 0 and illegal = 0.
  - The first FETCH executes on the first edge after reset deasserts.
- Tie-off: zero is ignored outside BRANCH; pcen = 0 in BRANCH when zero = 0.

Optional Feature:
- MULTICYCLE_MEM_WAIT_EN
- Defined:
  - Adds input port mem_ready (1 bit).
  - FETCH, MEMRD and MEMWR hold their state and all their outputs while mem_ready = 0.
  - pcwrite, irwrite and memwrite are gated with mem_ready, so each fires exactly once, on the cycle mem_ready = 1.
  - Reset overrides the wait.
- Undefined: no mem_ready port exists, and memory completes in one cycle.

Test Plan:
- Reset mid-LW: reset = 1 while state = MEMRD → state = 0 next edge, with regwrite = 0 and memwrite = 0 throughout reset.
- R-type: op = 000, funct = 0001 → states 0, 1, 6, 7, 0; alucontrol = 110 in EXECUTE; regwrite = 1 and regdst = 1 only in ALUWB.
- LW then SW:
  - LW: states 0, 1, 2, 3, 4, with iord = 1 in MEMRD and memtoreg = 1 in MEMWB.
  - SW: states 0, 1, 2, 5, with memwrite = 1 for exactly one cycle.
- BEQ: op = 011 with zero = 1 → pcen = 1 and pcsrc = 01 in BRANCH; with zero = 0 → pcen = 0; 3 cycles either way.
- Illegal decode:
  - op = 111 → illegal pulses for 1 cycle in DECODE, then FETCH, with no writes.
  - R-type with funct = 1111 → illegal in EXECUTE and alucontrol = 010.
- With MULTICYCLE_MEM_WAIT_EN: mem_ready low for 3 cycles in FETCH → state stays 0 for 4 cycles, and pcen/irwrite assert only on the 4th cycle.
